// File: rtl/hcsr04_ranger_pkg.sv
// parking_pkg: constants and state type shared by the parking-sensor chain.
package parking_pkg;

   localparam int unsigned CLK_HZ  = 50_000_000;
   localparam int unsigned DST_W   = 12;
   localparam logic [DST_W-1:0] DST_MAX = DST_W'(4095);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      DONE
   } ranger_state_e;

endpackage

// File: rtl/hcsr04_ranger_if.sv
// hcsr04_ranger_if: sensor-side signals of the ranger plus its result outputs.
interface hcsr04_ranger_if
   import parking_pkg::*;
();

   logic             echo;
   logic             trig;
   logic [DST_W-1:0] binary_dst;
   logic             dst_valid;
   logic             timeout;

   // ranger side
   modport master (
      input  echo,
      output trig,
      output binary_dst,
      output dst_valid,
      output timeout
   );

   // sensor / consumer side
   modport slave (
      output echo,
      input  trig,
      input  binary_dst,
      input  dst_valid,
      input  timeout
   );

endinterface

// File: rtl/hcsr04_ranger_sync_2ff.sv
// sync_2ff: two-flop synchronizer for the asynchronous echo input.
module sync_2ff (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic q
);

   logic meta;

   // two-stage capture, cleared by reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: periodic HC-SR04 trigger, echo pulse timing and mm conversion.
module hcsr04_ranger
   import parking_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES      = 500,
   parameter int unsigned PERIOD_CYCLES    = 3_000_000,
   parameter int unsigned ECHO_WAIT_CYCLES = 1_500_000,
   parameter int unsigned MM_TICK_CYCLES   = 291
) (
   input  logic            clk,
   input  logic            n_rst,
   hcsr04_ranger_if.master sensor
);

   localparam int unsigned PER_W  = $clog2(PERIOD_CYCLES);
   localparam int unsigned TICK_W = $clog2(MM_TICK_CYCLES);

   localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
   localparam logic [PER_W-1:0]  WAIT_LAST = PER_W'(TRIG_CYCLES + ECHO_WAIT_CYCLES - 1);
   // Results must be written early enough for DONE to land on the last
   // period cycle, so the next TRIG still starts exactly one period later.
   localparam logic [PER_W-1:0]  END_LAST  = PER_W'(PERIOD_CYCLES - 2);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MM_TICK_CYCLES - 1);
   // The rise cycle is the first echo-high cycle of the first mm, so an mm
   // completes when the phase counter is one short of its wrap value.
   localparam logic [TICK_W-1:0] TICK_MM   = TICK_W'(MM_TICK_CYCLES - 2);

   ranger_state_e     state;
   ranger_state_e     state_nxt;
   logic [PER_W-1:0]  period_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic [DST_W-1:0]  mm_cnt;
   logic              echo_s;
   logic              echo_d;
   logic              rise;
   logic              fall;
   logic              wr_valid;
   logic              wr_timeout;
   logic              trig_r;
   logic              dst_valid_r;
   logic              timeout_r;
   logic [DST_W-1:0]  dst_r;

   sync_2ff u_echo_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (sensor.echo),
      .q     (echo_s)
   );

   assign rise = echo_s & ~echo_d;
   assign fall = ~echo_s & echo_d;

   // delayed copy of the synchronized echo for edge detection
   always_ff @(posedge clk) begin
      if (!n_rst) echo_d <= 1'b0;
      else        echo_d <= echo_s;
   end

   // state register
   always_ff @(posedge clk) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and result-write decode
   always_comb begin
      state_nxt  = state;
      wr_valid   = 1'b0;
      wr_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (period_cnt == PER_LAST) state_nxt = TRIG;
         end
         TRIG: begin
            if (period_cnt == TRIG_LAST) state_nxt = WAIT_ECHO;
         end
         WAIT_ECHO: begin
            if (rise) begin
               state_nxt = MEASURE;
            end else if (period_cnt == WAIT_LAST || period_cnt >= END_LAST) begin
               state_nxt  = DONE;
               wr_timeout = 1'b1;
            end
         end
         MEASURE: begin
            if (fall) begin
               state_nxt = DONE;
               wr_valid  = 1'b1;
            end else if (period_cnt >= END_LAST) begin
               state_nxt  = DONE;
               wr_timeout = 1'b1;
            end
         end
         DONE: begin
            state_nxt = (period_cnt == PER_LAST) ? TRIG : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // period counter: cleared on TRIG entry, counts up and holds at period end
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         period_cnt <= PER_LAST;
      end else if (state_nxt == TRIG && state != TRIG) begin
         period_cnt <= '0;
      end else if (period_cnt != PER_LAST) begin
         period_cnt <= period_cnt + PER_W'(1);
      end
   end

   // echo-width to mm conversion, saturating at DST_MAX
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         tick_cnt <= '0;
         mm_cnt   <= '0;
      end else if (state == WAIT_ECHO && rise) begin
         tick_cnt <= '0;
         mm_cnt   <= '0;
      end else if (state == MEASURE && !fall) begin
         tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
         if (tick_cnt == TICK_MM && mm_cnt != DST_MAX) begin
            mm_cnt <= mm_cnt + DST_W'(1);
         end
      end
   end

   // registered trigger and result outputs
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         trig_r      <= 1'b0;
         dst_r       <= DST_MAX;
         dst_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         trig_r      <= (state_nxt == TRIG);
         dst_valid_r <= wr_valid | wr_timeout;
         if (wr_valid) begin
            dst_r     <= mm_cnt;
            timeout_r <= 1'b0;
         end else if (wr_timeout) begin
            dst_r     <= DST_MAX;
            timeout_r <= 1'b1;
         end
      end
   end

   assign sensor.trig       = trig_r;
   assign sensor.binary_dst = dst_r;
   assign sensor.dst_valid  = dst_valid_r;
   assign sensor.timeout    = timeout_r;

endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: directed and randomized checks of the HC-SR04 ranger.
module tb_hcsr04_ranger;

   localparam int TRIG   = 5;
   localparam int PERIOD = 2000;
   localparam int WAIT   = 500;
   localparam int TICK   = 3;
   localparam int MAXD   = 4095;

   logic clk;
   logic n_rst;

   int n_assert   = 0;
   int n_fail     = 0;
   int cyc        = 0;
   int valid_cnt  = 0;
   int valid_cnt2 = 0;
   int last_rise  = 0;

   hcsr04_ranger_if bus ();
   hcsr04_ranger_if bus2 ();

   hcsr04_ranger #(
      .TRIG_CYCLES      (TRIG),
      .PERIOD_CYCLES    (PERIOD),
      .ECHO_WAIT_CYCLES (WAIT),
      .MM_TICK_CYCLES   (TICK)
   ) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .sensor (bus.master)
   );

   hcsr04_ranger #(
      .TRIG_CYCLES      (TRIG),
      .PERIOD_CYCLES    (20000),
      .ECHO_WAIT_CYCLES (WAIT),
      .MM_TICK_CYCLES   (TICK)
   ) dut_long (
      .clk    (clk),
      .n_rst  (n_rst),
      .sensor (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock, sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.dst_valid === 1'b1)  valid_cnt++;
      if (bus2.dst_valid === 1'b1) valid_cnt2++;
   endtask

   task automatic await_rise(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         step();
         if (bus.trig === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_trig_seen"}, 32'(seen), 32'd1);
      chk({tag, "_spacing"}, 32'(cyc - last_rise), 32'(PERIOD));
      last_rise = cyc;
   endtask

   task automatic await_fall(input string tag, output int f);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.trig === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      f = cyc;
      chk({tag, "_fall_seen"}, 32'(seen), 32'd1);
      chk({tag, "_trig_width"}, 32'(f - last_rise), 32'(TRIG));
   endtask

   task automatic next_period(input string tag, output int f);
      await_rise(tag);
      await_fall(tag, f);
   endtask

   task automatic wait_valid(input string tag, input int budget, output int t);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (bus.dst_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      t = cyc;
      chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
   endtask

   // result must appear exactly 3 clocks after echo was dropped, as one pulse
   task automatic expect_result(input string tag, input int exp_dst, input int exp_to);
      step();
      chk({tag, "_lat1"}, 32'(bus.dst_valid), 32'd0);
      step();
      chk({tag, "_lat2"}, 32'(bus.dst_valid), 32'd0);
      step();
      chk({tag, "_valid"}, 32'(bus.dst_valid), 32'd1);
      chk({tag, "_dst"}, 32'(bus.binary_dst), 32'(exp_dst));
      chk({tag, "_timeout"}, 32'(bus.timeout), 32'(exp_to));
      step();
      chk({tag, "_single"}, 32'(bus.dst_valid), 32'd0);
   endtask

   initial begin
      int f;
      int t;
      int r;
      int d;
      int n;
      int v0;
      int d0;
      bit seen;

      n_rst     = 1'b0;
      bus.echo  = 1'b0;
      bus2.echo = 1'b0;

      // reset held for 4 clocks
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_dst", 32'(bus.binary_dst), 32'(MAXD));
         chk("rst_valid", 32'(bus.dst_valid), 32'd0);
         chk("rst_timeout", 32'(bus.timeout), 32'd0);
         chk("rst_trig", 32'(bus.trig), 32'd0);
      end
      n_rst = 1'b1;
      step();
      chk("first_trig", 32'(bus.trig), 32'd1);
      last_rise = cyc;
      await_fall("first", f);

      // 300-cycle echo starting 100 clocks after trig falls
      repeat (100) step();
      bus.echo = 1'b1;
      repeat (300) step();
      bus.echo = 1'b0;
      expect_result("echo300", 300 / TICK, 0);

      // no echo: timeout result 500 clocks after trig falls
      next_period("noecho", f);
      wait_valid("noecho", WAIT + 50, t);
      chk("noecho_delay", 32'(t - f), 32'(WAIT));
      chk("noecho_dst", 32'(bus.binary_dst), 32'(MAXD));
      chk("noecho_timeout", 32'(bus.timeout), 32'd1);

      // short echo after a timeout clears the timeout flag
      next_period("echo30", f);
      repeat (40) step();
      bus.echo = 1'b1;
      repeat (30) step();
      bus.echo = 1'b0;
      expect_result("echo30", 30 / TICK, 0);

      // echo stuck high: timeout on the last cycle of the period
      next_period("stuck", f);
      r = last_rise;
      repeat (50) step();
      bus.echo = 1'b1;
      wait_valid("stuck", PERIOD + 100, t);
      chk("stuck_at", 32'(t - r), 32'(PERIOD - 1));
      chk("stuck_dst", 32'(bus.binary_dst), 32'(MAXD));
      chk("stuck_timeout", 32'(bus.timeout), 32'd1);
      next_period("stuck_next", f);
      bus.echo = 1'b0;
      wait_valid("stuck_release", WAIT + 50, t);
      chk("stuck_release_delay", 32'(t - f), 32'(WAIT));
      chk("stuck_release_timeout", 32'(bus.timeout), 32'd1);

      // randomized widths against floor(N / TICK)
      for (int k = 0; k < 4; k++) begin
         next_period("rand", f);
         d = int'($urandom_range(2, 120));
         n = int'($urandom_range(1, 360));
         repeat (d) step();
         bus.echo = 1'b1;
         repeat (n) step();
         bus.echo = 1'b0;
         expect_result($sformatf("rand_w%0d", n), n / TICK, 0);
      end

      // echo pulses in IDLE and in TRIG are ignored
      v0 = valid_cnt;
      d0 = int'(bus.binary_dst);
      repeat (30) step();
      bus.echo = 1'b1;
      repeat (20) step();
      bus.echo = 1'b0;
      await_rise("pulse");
      bus.echo = 1'b1;
      repeat (2) step();
      bus.echo = 1'b0;
      await_fall("pulse", f);
      chk("pulse_novalid", 32'(valid_cnt - v0), 32'd0);
      chk("pulse_dst", 32'(bus.binary_dst), 32'(d0));
      repeat (30) step();
      bus.echo = 1'b1;
      repeat (60) step();
      bus.echo = 1'b0;
      expect_result("after_pulse", 60 / TICK, 0);

      // reset for one clock in the middle of a measurement
      next_period("midrst", f);
      repeat (20) step();
      bus.echo = 1'b1;
      repeat (100) step();
      v0    = valid_cnt;
      n_rst = 1'b0;
      step();
      chk("midrst_dst", 32'(bus.binary_dst), 32'(MAXD));
      chk("midrst_trig", 32'(bus.trig), 32'd0);
      chk("midrst_valid", 32'(bus.dst_valid), 32'd0);
      chk("midrst_timeout", 32'(bus.timeout), 32'd0);
      n_rst    = 1'b1;
      bus.echo = 1'b0;
      step();
      chk("midrst_restart", 32'(bus.trig), 32'd1);
      chk("long_restart", 32'(bus2.trig), 32'd1);
      last_rise = cyc;
      await_fall("midrst", f);
      repeat (10) step();
      chk("midrst_novalid", 32'(valid_cnt - v0), 32'd0);
      chk("midrst_dst_hold", 32'(bus.binary_dst), 32'(MAXD));

      // long period instance: 13000-cycle echo saturates at DST_MAX
      seen = (bus2.trig === 1'b0);
      for (int i = 0; i < 50 && !seen; i++) begin
         step();
         if (bus2.trig === 1'b0) seen = 1'b1;
      end
      chk("long_fall_seen", 32'(seen), 32'd1);
      bus2.echo = 1'b1;
      repeat (13000) step();
      bus2.echo = 1'b0;
      v0 = valid_cnt2;
      repeat (2) step();
      chk("long_lat", 32'(bus2.dst_valid), 32'd0);
      step();
      chk("long_valid", 32'(bus2.dst_valid), 32'd1);
      chk("long_dst", 32'(bus2.binary_dst), 32'(MAXD));
      chk("long_timeout", 32'(bus2.timeout), 32'd0);
      chk("long_single", 32'(valid_cnt2 - v0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
